// File: rtl/opacc_cdrain_if.sv
// Drain-side bundle between the tile drain engine, its opacc and the row consumer.
// slave = drain engine view, master = controller/opacc/consumer view.
interface opacc_cdrain_if #(
  parameter int nregs = 2,
  parameter int XLEN  = 8,
  parameter int vl    = 4,
  parameter int ml    = 4
) ();
  localparam int AW = (nregs > 1) ? $clog2(nregs) : 1;
  localparam int DW = vl * XLEN;
  localparam int RW = $clog2(ml) + 1;

  logic          start;
  logic [AW-1:0] start_addr;
  logic          clear;
  logic          busy;
  logic          done;

  logic [AW-1:0] cst_addr;
  logic          acc_pop;
  logic          acc_zero;
  logic [DW-1:0] co;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic          out_last;

  modport slave (
    input  start, start_addr, clear, co, out_ready,
    output busy, done, cst_addr, acc_pop, acc_zero,
           out_valid, out_data, out_row, out_last
  );

  modport master (
    output start, start_addr, clear, co, out_ready,
    input  busy, done, cst_addr, acc_pop, acc_zero,
           out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/opacc_cdrain.sv
// Drains one opacc tile row by row into a single-entry valid/ready output register.
// First row valid 2 cycles after start, then 1 row/cycle; out_ready low stalls pops.
module opacc_cdrain #(
  parameter int nregs = 2,
  parameter int XLEN  = 8,
  parameter int vl    = 4,
  parameter int ml    = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  opacc_cdrain_if.slave  bus
);
  localparam int AW = (nregs > 1) ? $clog2(nregs) : 1;
  localparam int DW = vl * XLEN;
  localparam int RW = $clog2(ml) + 1;
  localparam logic [RW-1:0] LAST = RW'(ml - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic          r_clr;
  logic [RW-1:0] r_cnt;
  logic          r_vld;
  logic [DW-1:0] r_dat;
  logic [RW-1:0] r_row;
  logic          r_done;

  logic w_accept;
  logic w_take;
  logic w_pop;
  logic w_fin;
  logic w_busy;

  assign w_accept = r_vld & bus.out_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_DRAIN;
      S_DRAIN: if (w_pop && (r_cnt == LAST)) w_next = S_FLUSH;
      S_FLUSH: if (w_accept) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A pop only happens when the output register can take the row this edge.
  always_comb begin
    w_take = 1'b0;
    w_pop  = 1'b0;
    w_fin  = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE:  w_take = bus.start;
      S_DRAIN: begin
        w_busy = 1'b1;
        w_pop  = ~r_vld | bus.out_ready;
      end
      S_FLUSH: begin
        w_busy = 1'b1;
        w_fin  = w_accept;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_addr <= '0;
      r_clr  <= 1'b0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_take) begin
        r_addr <= bus.start_addr;
        r_clr  <= bus.clear;
        r_cnt  <= '0;
      end
      if (w_pop) begin
        r_dat <= bus.co;
        r_row <= r_cnt;
        r_cnt <= r_cnt + RW'(1);
        r_vld <= 1'b1;
      end else if (w_accept) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.cst_addr  = r_addr;
  assign bus.acc_pop   = w_pop;
  assign bus.acc_zero  = w_pop & r_clr;
  assign bus.out_valid = r_vld;
  assign bus.out_data  = r_dat;
  assign bus.out_row   = r_row;
  assign bus.out_last  = r_vld & (r_row == LAST);
endmodule

// File: tb/tb_opacc_cdrain.sv
// Directed bench for opacc_cdrain with a behavioural opacc tile store.
module tb_opacc_cdrain;
  localparam int NR = 2;
  localparam int XL = 8;
  localparam int VL = 4;
  localparam int ML = 4;
  localparam int DW = VL * XL;

  logic clk;
  logic rst_n;
  logic preload;
  int   total;
  int   bad;

  logic [DW-1:0] tile [NR][ML];

  opacc_cdrain_if #(.nregs(NR), .XLEN(XL), .vl(VL), .ml(ML)) bus ();

  opacc_cdrain #(.nregs(NR), .XLEN(XL), .vl(VL), .ml(ML)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Tile 1 row r element j = r*j; tile 0 uses the same pattern xor 0x55.
  function automatic logic [DW-1:0] mk_row(input int a, input int r);
    logic [DW-1:0] v;
    v = '0;
    for (int j = 0; j < VL; j++)
      v[j*XL +: XL] = (a == 1) ? XL'(r * j) : (XL'(r * j) ^ 8'h55);
    return v;
  endfunction

  // opacc model: pop rotates the tile up one row, or shifts in zeros when cleared.
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < NR; a++)
        for (int r = 0; r < ML; r++)
          tile[a][r] <= mk_row(a, r);
    end else if (bus.acc_pop) begin
      for (int r = 0; r < ML - 1; r++)
        tile[bus.cst_addr][r] <= tile[bus.cst_addr][r+1];
      tile[bus.cst_addr][ML-1] <= bus.acc_zero ? '0 : tile[bus.cst_addr][0];
    end
  end

  assign bus.co = tile[bus.cst_addr][0];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  function automatic logic rdy_of(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 3) == 1;
      4:       return cyc > 10;
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: ready high, 1: ready 1,0,0 pattern, 3: stray start mid-drain, 4: 10-cycle stall
  task automatic drain(input int addr, input logic clr, input int mode, input logic zero_exp);
    int k, pops, first_v, done_cyc;
    logic got_done, stalled, pl;
    logic [DW-1:0] pd, expd;
    logic [2:0] pr;
    k = 0; pops = 0; first_v = -1; done_cyc = -1;
    got_done = 1'b0; stalled = 1'b0; pl = 1'b0; pd = '0; pr = '0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = 1'(addr);
    bus.clear      = clr;
    bus.out_ready  = rdy_of(mode, 0);
    for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
      @(negedge clk);
      bus.start      = (mode == 3) && (cyc == 2);
      bus.start_addr = ((mode == 3) && (cyc == 2)) ? 1'b0 : 1'(addr);
      bus.clear      = ((mode == 3) && (cyc == 2)) ? 1'b1 : clr;
      bus.out_ready  = rdy_of(mode, cyc);
      #1;
      if (k < ML) begin
        chk("cst_addr", bus.cst_addr, addr);
        chk("done_early", bus.done, 0);
        chk("busy", bus.busy, 1);
        if (bus.acc_pop) begin
          pops++;
          chk("acc_zero_pop", bus.acc_zero, clr);
        end else begin
          chk("acc_zero_nopop", bus.acc_zero, 0);
        end
        if (stalled) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, pd);
          chk("stall_row", bus.out_row, pr);
          chk("stall_last", bus.out_last, pl);
        end
        if (bus.out_valid && first_v < 0) first_v = cyc;
        if (mode == 4 && cyc == 10) begin
          chk("hold_pops", pops, 1);
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_row", bus.out_row, 0);
        end
        if (bus.out_valid && bus.out_ready) begin
          expd = zero_exp ? '0 : mk_row(addr, k);
          chk("row_data", bus.out_data, expd);
          chk("row_idx", bus.out_row, k);
          chk("row_last", bus.out_last, (k == ML - 1));
          k++;
        end
        stalled = bus.out_valid && !bus.out_ready;
        pd = bus.out_data;
        pr = bus.out_row;
        pl = bus.out_last;
      end else begin
        chk("done_pulse", bus.done, 1);
        chk("busy_end", bus.busy, 0);
        chk("valid_end", bus.out_valid, 0);
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("drain_finished", got_done, 1);
    chk("rows_seen", k, ML);
    chk("pop_count", pops, ML);
    if (mode == 0) begin
      chk("first_valid_lat", first_v, 2);
      chk("done_lat", done_cyc, 6);
    end
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; preload = 1'b0;
    bus.start = 1'b0; bus.start_addr = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_pop", bus.acc_pop, 0);
    chk("rst_addr", bus.cst_addr, 0);
    chk("rst_data", bus.out_data, 0);
    rst_n = 1'b1;

    do_preload();
    drain(1, 1'b0, 0, 1'b0);
    do_preload();
    drain(1, 1'b0, 1, 1'b0);
    do_preload();
    drain(1, 1'b1, 0, 1'b0);
    drain(1, 1'b0, 0, 1'b1);
    do_preload();
    drain(1, 1'b0, 3, 1'b0);
    do_preload();
    drain(0, 1'b0, 4, 1'b0);

    // Reset after two rows have been accepted.
    do_preload();
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = 1'b1; bus.clear = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_row", bus.out_row, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_pop", bus.acc_pop, 0);
    chk("mid_rst_addr", bus.cst_addr, 0);
    chk("mid_rst_row", bus.out_row, 0);
    chk("mid_rst_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", bus.out_valid, 0);
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_pop", bus.acc_pop, 0);
    end
    do_preload();
    drain(1, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/opacc_cdrain.md
OPACC_CDRAIN -- requirements
Module: opacc_cdrain

Interface
REQ-001 Parameter nregs, default 2, number of accumulator tile registers in the attached opacc.
REQ-002 Parameter XLEN, default 8, element width in bits.
REQ-003 Parameter vl, default 4, elements per accumulator row.
REQ-004 Parameter ml, default 4, rows per accumulator tile.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to drain a tile.
REQ-008 start_addr  input  $clog2(nregs)  tile register to drain, sampled with start.
REQ-009 clear  input  1  sampled with start; 1 = shift zeros into the tile while draining.
REQ-010 busy  output  1  high from accepted start until the last row is accepted downstream.
REQ-011 done  output  1  one-cycle pulse in the cycle after the last row is accepted.
REQ-012 cst_addr  output  $clog2(nregs)  tile select driven to opacc.
REQ-013 acc_pop  output  1  one-cycle strobe: opacc shifts its tile by one row.
REQ-014 acc_zero  output  1  equals the latched clear while acc_pop is high; otherwise 0.
REQ-015 co  input  vl*XLEN  opacc head row, valid combinationally for the current cst_addr.
REQ-016 out_valid  output  1  out_data holds a row.
REQ-017 out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
REQ-018 out_data  output  vl*XLEN  row data; element j in bits [j*XLEN +: XLEN].
REQ-019 out_row  output  $clog2(ml)+1  index of the row in out_data, 0 = first row popped.
REQ-020 out_last  output  1  high with out_valid on row ml-1.

Function
REQ-021 FSM states: IDLE, DRAIN, FLUSH.
REQ-022 IDLE: start=1 latches start_addr and clear, sets pop counter to 0, and moves to DRAIN on the next edge.
REQ-023 start while busy is ignored; latched address and clear stay unchanged.
REQ-024 cst_addr holds the latched address during DRAIN and FLUSH, and the last latched value in IDLE.
REQ-025 DRAIN: a single-entry output register loads co when empty, or when full and accepted in the same cycle.
REQ-026 acc_pop is high exactly in the cycles where the output register loads; the pop counter increments on each pop.
REQ-027 After pop ml-1 the FSM moves to FLUSH; acc_pop never exceeds ml per tile.
REQ-028 Throughput: with out_ready held high, one row per cycle; first out_valid appears 2 cycles after start.
REQ-029 out_data, out_row and out_last stay stable while out_valid=1 and out_ready=0.
REQ-030 FLUSH: when the last row is accepted, out_valid falls, busy falls, done pulses, and the FSM returns to IDLE.
REQ-031 Row order is pop order: out_row k carries the k-th row from co.
REQ-032 The block performs no arithmetic; data passes through bit-exact.

Reset
REQ-033 Reset asserted (low) at any time forces IDLE immediately: busy, done, acc_pop, acc_zero and out_valid go to 0; cst_addr, out_data, out_row and the counter go to 0.
REQ-034 A drain interrupted by reset is abandoned; after reset deasserts, nothing is emitted until a new start.

Verification
REQ-035 With ml=vl=4 and XLEN=8, tile rows preloaded as row i element j = i*j, start addr 1, out_ready=1 -> rows 0..3 appear on 4 consecutive cycles, matching the preload; out_last on row 3; done one cycle later; cst_addr=1 throughout.
REQ-036 Same drain with out_ready toggling 1,0,0,1,... -> no row is lost or duplicated; data stays stable while stalled; acc_pop count = 4.
REQ-037 clear=1 drain, then a second drain of the same tile -> the second drain returns all-zero rows; acc_zero high on every pop of the first drain only.
REQ-038 start pulsed again mid-drain with addr 0 -> ignored; cst_addr stays 1; exactly 4 rows are produced.
REQ-039 reset pulsed low after 2 rows accepted -> outputs clear in the same cycle; no done pulse; a new start then drains 4 rows normally.
REQ-040 out_ready=0 for 10 cycles from start -> exactly one pop, out_valid held with row 0, busy=1 throughout.
